// File: rtl/sprite_engine_pkg.sv
// Shared graphics definitions: sprite table constants, the evaluation FSM
// encoding and the per-scanline slot record.
package sprite_engine_pkg;

   localparam int NUM_SPRITES  = 32;
   localparam int SPRITE_SIZE  = 16;
   localparam int SPRITE_SLOTS = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_SWAP
   } eval_state_t;

   typedef struct packed {
      logic [4:0] id;
      logic [9:0] x;
      logic [3:0] row;
      logic       flip;
   } slot_t;

endpackage

// File: rtl/sprite_engine_if.sv
// Sprite command bus from the execute stage into the sprite engine.
interface sprite_engine_if;

   logic       sprite_pos;
   logic       sprite_attr;
   logic [4:0] sprite_sel;
   logic [9:0] sprite_x;
   logic [8:0] sprite_y;
   logic       sprite_vis;

   modport master (
      output sprite_pos, sprite_attr, sprite_sel, sprite_x, sprite_y, sprite_vis
   );

   modport slave (
      input sprite_pos, sprite_attr, sprite_sel, sprite_x, sprite_y, sprite_vis
   );

endinterface

// File: rtl/sprite_slot_match.sv
// Per-slot horizontal coverage test and texel column (with X mirror).
module sprite_slot_match
   import sprite_engine_pkg::*;
#(
   parameter int SIZE = SPRITE_SIZE
) (
   input  logic       i_valid,
   input  logic       i_active,
   input  logic [9:0] i_hcount,
   input  logic [9:0] i_x,
   input  logic       i_flip,
   output logic       o_match,
   output logic [3:0] o_col
);

   localparam logic [10:0] SIZE11 = 11'(SIZE);
   localparam logic [3:0]  LAST   = 4'(SIZE - 1);

   logic [10:0] w_dx;

   // 11-bit difference so pixels left of the sprite never alias into range
   assign w_dx    = {1'b0, i_hcount} - {1'b0, i_x};
   assign o_match = i_valid && i_active && (w_dx < SIZE11);
   assign o_col   = i_flip ? (LAST - w_dx[3:0]) : w_dx[3:0];

endmodule

// File: rtl/sprite_engine.sv
// Sprite attribute table, per-scanline slot evaluation (double-buffered) and
// registered per-pixel priority hit reporting.
module sprite_engine
   import sprite_engine_pkg::*;
#(
   parameter int SIZE  = SPRITE_SIZE,
   parameter int SLOTS = SPRITE_SLOTS
) (
   input  logic             clk,
   input  logic             reset,
   sprite_engine_if.slave   cmd,
   input  logic             line_start,
   input  logic [8:0]       next_line,
   input  logic [9:0]       hcount,
   input  logic             active,
   output logic             sprite_hit,
   output logic [4:0]       sprite_id,
   output logic [3:0]       sprite_row,
   output logic [3:0]       sprite_col,
   output logic             overflow,
   output logic             eval_busy
);

   localparam int             CW     = $clog2(SLOTS + 1);
   localparam logic [9:0]     SIZE10 = 10'(SIZE);
   localparam logic [4:0]     LAST_I = 5'(NUM_SPRITES - 1);
   localparam logic [CW-1:0]  SLOTSC = CW'(SLOTS);

   logic [9:0]             r_x [NUM_SPRITES];
   logic [8:0]             r_y [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] r_vis;
   logic [NUM_SPRITES-1:0] r_flip;

   eval_state_t r_state, w_state_nxt;
   logic        w_busy, w_scan_en, w_swap_en;

   logic [8:0]    r_line;
   logic [4:0]    r_idx;
   slot_t         r_pend [SLOTS];
   slot_t         r_act  [SLOTS];
   logic [CW-1:0] r_pend_cnt, r_act_cnt;
   logic          r_ovf_pend, r_overflow;

   logic [9:0] w_diff;
   logic       w_qual;
   slot_t      w_new;

   logic [SLOTS-1:0] w_match;
   logic [3:0]       w_col [SLOTS];
   logic             w_hit;
   logic [4:0]       w_id;
   logic [3:0]       w_row, w_pcol;
   logic             r_hit;
   logic [4:0]       r_id;
   logic [3:0]       r_row, r_col;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            r_x[i] <= '0;
            r_y[i] <= '0;
         end
         r_vis  <= '0;
         r_flip <= '0;
      end else begin
         if (cmd.sprite_pos) begin
            r_x[cmd.sprite_sel] <= cmd.sprite_x;
            r_y[cmd.sprite_sel] <= cmd.sprite_y;
         end
         if (cmd.sprite_attr) begin
            r_vis[cmd.sprite_sel]  <= cmd.sprite_vis;
            r_flip[cmd.sprite_sel] <= cmd.sprite_x[0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (line_start) begin
         w_state_nxt = ST_SCAN;
      end else begin
         case (r_state)
            ST_SCAN: if (r_idx == LAST_I) w_state_nxt = ST_SWAP;
            ST_SWAP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      w_busy    = (r_state != ST_IDLE);
      w_scan_en = (r_state == ST_SCAN) && !line_start;
      w_swap_en = (r_state == ST_SWAP) && !line_start;
   end

   // Table read is combinational on the pre-edge contents, so a same-cycle
   // command to the scanned entry is only seen by later evaluations.
   assign w_diff = {1'b0, r_line} - {1'b0, r_y[r_idx]};
   assign w_qual = r_vis[r_idx] && (w_diff < SIZE10);
   assign w_new  = '{id: r_idx, x: r_x[r_idx], row: w_diff[3:0], flip: r_flip[r_idx]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_line     <= '0;
         r_idx      <= '0;
         r_pend_cnt <= '0;
         r_act_cnt  <= '0;
         r_ovf_pend <= 1'b0;
         r_overflow <= 1'b0;
         for (int unsigned k = 0; k < SLOTS; k++) begin
            r_pend[k] <= '0;
            r_act[k]  <= '0;
         end
      end else begin
         if (line_start) begin
            r_line     <= next_line;
            r_idx      <= '0;
            r_pend_cnt <= '0;
            r_ovf_pend <= 1'b0;
         end else if (w_scan_en) begin
            r_idx <= r_idx + 5'd1;
            if (w_qual) begin
               if (r_pend_cnt < SLOTSC) begin
                  for (int unsigned k = 0; k < SLOTS; k++)
                     if (r_pend_cnt == CW'(k)) r_pend[k] <= w_new;
                  r_pend_cnt <= r_pend_cnt + 1'b1;
               end else begin
                  r_ovf_pend <= 1'b1;
               end
            end
         end
         if (w_swap_en) begin
            r_act      <= r_pend;
            r_act_cnt  <= r_pend_cnt;
            r_overflow <= r_ovf_pend;
         end
      end
   end

   for (genvar g = 0; g < SLOTS; g++) begin : g_slot
      sprite_slot_match #(.SIZE(SIZE)) u_match (
         .i_valid  (CW'(g) < r_act_cnt),
         .i_active (active),
         .i_hcount (hcount),
         .i_x      (r_act[g].x),
         .i_flip   (r_act[g].flip),
         .o_match  (w_match[g]),
         .o_col    (w_col[g])
      );
   end

   always_comb begin
      w_hit  = 1'b0;
      w_id   = '0;
      w_row  = '0;
      w_pcol = '0;
      for (int unsigned k = 0; k < SLOTS; k++) begin
         if (w_match[k] && !w_hit) begin
            w_hit  = 1'b1;
            w_id   = r_act[k].id;
            w_row  = r_act[k].row;
            w_pcol = w_col[k];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hit <= 1'b0;
         r_id  <= '0;
         r_row <= '0;
         r_col <= '0;
      end else begin
         r_hit <= w_hit;
         r_id  <= w_id;
         r_row <= w_row;
         r_col <= w_pcol;
      end
   end

   assign sprite_hit = r_hit;
   assign sprite_id  = r_id;
   assign sprite_row = r_row;
   assign sprite_col = r_col;
   assign overflow   = r_overflow;
   assign eval_busy  = w_busy;

endmodule

// File: doc/sprite_engine.md
# sprite_engine

Graphics-side consumer of the sprite command interface emitted by the execute stage. Holds a 32-entry sprite attribute table written by registered sprite commands. Once per scanline it evaluates which sprites cover the next line into a double-buffered slot list. During active video it reports, per pixel, the highest-priority sprite hit and the texel coordinates the pixel fetch stage needs.

## Interface
- `SIZE`, default 16: sprite width and height in pixels; a power of two, at most 16.
- `SLOTS`, default 4: maximum number of sprites per scanline.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `sprite_pos` in 1: one-cycle pulse; writes X/Y of entry `sprite_sel`.
- `sprite_attr` in 1: one-cycle pulse; writes vis/flip of entry `sprite_sel`.
- `sprite_sel` in 5: target table entry.
- `sprite_x` in 10: X position on `sprite_pos`; bit 0 is the flip flag on `sprite_attr`.
- `sprite_y` in 9: Y position on `sprite_pos`.
- `sprite_vis` in 1: visibility bit written on `sprite_attr`.
- `line_start` in 1: one-cycle pulse from the VGA timing block at the start of hblank.
- `next_line` in 9: scanline number to evaluate; sampled with `line_start`.
- `hcount` in 10: current pixel column.
- `active` in 1: visible region.
- `sprite_hit` out 1: pixel is covered by a sprite.
- `sprite_id` out 5: table index of the winning sprite.
- `sprite_row` out 4: texel row in the sprite.
- `sprite_col` out 4: texel column, mirrored if flip is set.
- `overflow` out 1: more than `SLOTS` sprites were found on the last evaluated line.
- `eval_busy` out 1: evaluation FSM is not IDLE.

## Operation
- Table entry: x[9:0], y[8:0], vis, flip. Reset sets vis=0 and flip=0; x and y reset to 0.
- Commands:
  - `sprite_pos` writes x and y.
  - `sprite_attr` writes vis=`sprite_vis` and flip=`sprite_x[0]`.
  - If both pulse in the same cycle, both writes apply.
  - Commands are accepted in every cycle, including during evaluation.
- Evaluation FSM states: IDLE, SCAN, SWAP.
  - IDLE → SCAN on `line_start`: latch `next_line` as L, set scan index i=0, clear the pending slot count and the pending overflow flag.
  - SCAN: one entry per cycle. Entry i qualifies if vis=1 and the 10-bit unsigned value (L − y) is less than SIZE.
  - On a qualifying entry with count < SLOTS: store {i, x, row=(L−y)[3:0], flip} into pending slot[count], and increment count.
  - On a qualifying entry with count = SLOTS: set pending overflow.
  - After i=31, go to SWAP.
  - SWAP: copy the pending slots and count to the active set, copy pending overflow to `overflow`, then go to IDLE. This takes 1 cycle.
  - `line_start` during SCAN or SWAP restarts the scan at i=0 with a new L. The active set is untouched.
- Read/write collision: if a command hits entry i in the same cycle SCAN reads entry i, the scan uses the old contents.
- Y wrap: L − y is computed modulo 1024. A sprite at y=510 with SIZE=16 does not wrap onto line 0.
- Pixel match:
  - Active slot k matches if k < count, `active`=1, and the 11-bit unsigned value (hcount − x) is less than SIZE.
  - The lowest k wins, which is also the lowest table index.
  - col = (hcount − x)[3:0]; if flip=1, col = SIZE−1−col.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE, count=0 for both the pending and active sets.
- Command to table write latency: 1 cycle. A command takes effect from the next evaluation whose SCAN reads that entry after the write.
- Evaluation takes 33 cycles from `line_start` to the active set being updated (32 SCAN + 1 SWAP). `eval_busy`=1 throughout.
- Pixel outputs are registered, with 1-cycle latency from `hcount` and `active`. When `active`=0, `sprite_hit`=0 on the next cycle and `sprite_id`/`sprite_row`/`sprite_col` are 0.
- Reset asserted mid-scan aborts immediately: the table, both slot sets and all outputs clear.

## Structure
- Shared graphics package holds:
  - constants: `NUM_SPRITES`=32, `SPRITE_SIZE`, `SPRITE_SLOTS`;
  - FSM state encoding;
  - the slot record layout {id[4:0], x[9:0], row[3:0], flip}.
- One sub-module, `sprite_slot_match`: combinational per-slot X comparator and column mirror, instantiated `SLOTS` times. The priority encoder stays in `sprite_engine`.

## Test plan
- Reset, then `line_start` with next_line=100 and an empty table → after 33 cycles count=0 and `overflow`=0; with `active`=1, `sprite_hit` stays 0.
- Entry 3: x=40, y=95, vis=1, flip=0; evaluate line 100; hcount=45 → 1 cycle later `sprite_hit`=1, id=3, row=5, col=5. hcount=56 → `sprite_hit`=0.
- Same sprite with flip=1 → at hcount=45, col=10. Entry 7 overlapping at x=42 → id=3 still wins; at hcount=57, id=7.
- Entries 0–5 all visible at y=100; evaluate line 100 → slots hold ids 0–3 and `overflow`=1. The next empty line clears `overflow`.
- Entry 10 at y=510; evaluate line 2 → no hit. Command writes entry 10 in the cycle SCAN reads it (cycle 11 after `line_start`) → the old value is used; the following line uses the new value.
- `line_start` at SCAN cycle 20 → scan restarts, SWAP occurs 33 cycles after the second pulse; assert `reset` mid-scan → all outputs 0 and `eval_busy`=0 immediately.
